// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the serial console line receiver.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_IDLE
    } rx_state_t;

    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_CR = 8'h0D;

    localparam int HELLO_LEN = 11;
    localparam logic [8*HELLO_LEN-1:0] HELLO_STR = "Hello World";

    // Byte idx of HELLO_STR, index 0 being the first character ('H').
    function automatic logic [7:0] hello_byte(input int idx);
        return HELLO_STR[8*(HELLO_LEN-1-idx) +: 8];
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 deserializer: 2-flop synchronizer, bit FSM, byte/frame-error pulses.
// Byte pulses one cycle after the mid-stop sample; no backpressure, bytes are never held.
module uart_rx_byte
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST      = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    rx_state_t     state, state_n;
    logic          rx_meta, rxs;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          cnt_clr, shift_en, emit, ferr;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta    <= 1'b1;
            rxs        <= 1'b1;
            state      <= ST_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_meta    <= rxd;
            rxs        <= rx_meta;
            state      <= state_n;
            cnt        <= cnt_clr ? '0 : cnt + 1'b1;
            bit_idx    <= shift_en ? bit_idx + 1'b1 : bit_idx;
            byte_valid <= emit;
            frame_err  <= ferr;
        end
    end

    always_ff @(posedge clk) begin
        if (shift_en) shreg <= {rxs, shreg[7:1]};
        if (emit)     byte_data <= shreg;
    end

    // Counter restarts at every phase boundary so each wait is measured from its own entry.
    always_comb begin
        state_n  = state;
        cnt_clr  = 1'b0;
        shift_en = 1'b0;
        emit     = 1'b0;
        ferr     = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_clr = 1'b1;
                if (!rxs) state_n = ST_START;
            end
            ST_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_clr = 1'b1;
                    state_n = rxs ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt == LAST) begin
                    cnt_clr  = 1'b1;
                    shift_en = 1'b1;
                    if (bit_idx == 3'd7) state_n = ST_STOP;
                end
            end
            ST_STOP: begin
                if (cnt == LAST) begin
                    cnt_clr = 1'b1;
                    if (rxs) begin
                        emit    = 1'b1;
                        state_n = ST_IDLE;
                    end else begin
                        ferr    = 1'b1;
                        state_n = ST_WAIT_IDLE;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                cnt_clr = 1'b1;
                if (rxs) state_n = ST_IDLE;
            end
            default: begin
                cnt_clr = 1'b1;
                state_n = ST_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/uart_line_rx.sv
// Console line receiver: assembles UART bytes into an LF-terminated line with random-access read.
// line_valid rises one cycle after the LF byte; while a line is held new bytes are dropped and flagged.
module uart_line_rx
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int LINE_MAX     = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rxd,
    input  logic                        line_ack,
    input  logic [$clog2(LINE_MAX)-1:0] rd_addr,
    output logic [7:0]                  rd_data,
    output logic                        line_valid,
    output logic [$clog2(LINE_MAX):0]   line_len,
    output logic                        hello_match,
    output logic                        frame_err,
    output logic                        overflow
);

    localparam int LW = $clog2(LINE_MAX);
    localparam logic [LW:0] MAX_LEN = (LW+1)'(LINE_MAX);
    localparam logic [LW:0] HLEN    = (LW+1)'(HELLO_LEN);

    logic          byte_valid;
    logic [7:0]    byte_data;
    logic [7:0]    line_buf [LINE_MAX];
    logic [LW:0]   len, len_eff;
    logic          ack_take, held, is_cr, is_lf, fits;
    logic          wr_en, drop, lf_take, hello_cmp;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .frame_err (frame_err)
    );

    // An ack landing with a byte frees the buffer first, so the byte starts the new line.
    assign ack_take = line_ack & line_valid;
    assign held     = line_valid & ~ack_take;
    assign len_eff  = ack_take ? '0 : len;

    assign is_cr   = (byte_data == ASCII_CR);
    assign is_lf   = (byte_data == ASCII_LF);
    assign fits    = (len_eff < MAX_LEN);
    assign wr_en   = byte_valid & ~held & ~is_cr & ~is_lf & fits;
    assign lf_take = byte_valid & ~held & is_lf;
    assign drop    = byte_valid & (held | (~is_cr & ~is_lf & ~fits));

    always_comb begin
        hello_cmp = (len_eff == HLEN);
        for (int i = 0; i < HELLO_LEN; i++) begin
            if (line_buf[LW'(i)] != hello_byte(i)) hello_cmp = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len         <= '0;
            line_valid  <= 1'b0;
            overflow    <= 1'b0;
            hello_match <= 1'b0;
        end else begin
            if (ack_take) begin
                len         <= '0;
                line_valid  <= 1'b0;
                overflow    <= 1'b0;
                hello_match <= 1'b0;
            end
            if (wr_en) len <= len_eff + 1'b1;
            if (drop)  overflow <= 1'b1;
            if (lf_take) begin
                line_valid  <= 1'b1;
                hello_match <= hello_cmp;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) line_buf[len_eff[LW-1:0]] <= byte_data;
    end

    assign rd_data  = line_buf[rd_addr];
    assign line_len = len;

endmodule
